inv_rotate: RTL and testbench
=============================

# inv_rotate

Inverse rho step for the Keccak decoder path. It walks all 25 lanes of the 1600-bit state held in the shared lane memory file. Each lane is rotated **right** by its rho offset and written back in place, undoing the encoder's left rotation. It combines its own control FSM and datapath, and drives the memory file's read/write/index port directly.

## Interface
Parameters:
- LANE_W, 64, lane width in bits; offsets are taken modulo LANE_W.
- N_LANES, 25, lanes per state; last index is N_LANES-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk).
- start  input  1  begin one full-state pass; sampled only in IDLE.
- lane_in  input  LANE_W  memory read data; valid the cycle after read is asserted.
- read  output  1  memory read strobe for lane `index`.
- write  output  1  memory write strobe; memory captures lane_out at `index` on this edge.
- index  output  5  lane index x+5y, 0..24.
- lane_out  output  LANE_W  rotated lane to memory.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when lane 24 has been written.

## Operation
- Offset ROM, indexed by lane index 0..24: 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14.
- FSM states and transitions:
  - IDLE: start=1 → READ, index←0, busy←1.
  - READ: read=1 for one cycle → LOAD.
  - LOAD: lane register←lane_in, shift counter←0.
    - If offset=0 → WRITE.
    - Otherwise → SHIFT.
  - SHIFT: lane register rotated right by 1 per cycle, counter+1.
    - When counter reaches offset-1 on this edge → WRITE.
  - WRITE: write=1, lane_out=lane register.
    - If index=24 → DONE.
    - Otherwise index+1 → READ.
  - DONE: done=1 for one cycle, busy←0 → IDLE.
- Rotation rule: rotr(v,r) = (v>>r)|(v<<(LANE_W-r)), applied bit-serially. The shift counter is 6 bits.
- Index wrap: index never exceeds 24. It returns to 0 only on the next accepted start.
- start while busy is ignored; a level-held start re-triggers only after returning to IDLE.
- read and write are never asserted in the same cycle.
- Reset is honoured in every state, including mid-pass:
  - rst=0 forces IDLE on the next edge; the memory contents are left as-is (partially processed).
  - All outputs are 0 on the cycle after reset: read, write, busy, done, index, lane_out.

## Timing
- Start to first read: start sampled in IDLE → read=1 on the next cycle.
- Per lane: 3 + offset cycles (READ, LOAD, offset×SHIFT, WRITE).
- Full pass: 75 + 680 = 755 cycles from start acceptance to DONE entry; done rises on cycle 756.
- lane_out is registered and stable throughout WRITE. It holds its last value otherwise.
- busy falls in the same cycle done pulses; a new start is accepted in the following IDLE cycle.

## Configuration
- INV_ROTATE_BARREL_EN:
  - Defined: LOAD captures rotr(lane_in, offset) through a combinational barrel rotator, SHIFT is never entered, each lane takes 3 cycles, and a full pass takes 75 cycles (done on cycle 76).
  - Undefined: bit-serial SHIFT as above.
- Memory contents after a pass are identical in both builds.

## Test plan
- Lane 1 = 64'h1, lane 2 = 64'h1, lane 0 = 64'hDEADBEEF, start pulse → lane 1 = 64'h8000_0000_0000_0000, lane 2 = 64'h4, lane 0 unchanged.
- Apply the encoder rotate to a random state, then inv_rotate → original state restored bit-exact for all 25 lanes.
- Cycle count: start at cycle 0 → done high at cycle 756 exactly, single-cycle pulse, busy low afterwards. With INV_ROTATE_BARREL_EN the pulse is at cycle 76.
- start re-asserted at cycle 100 and held to cycle 200 → no restart. index sequence remains monotonic 0..24 with one write per lane (25 writes total).
- rst=0 during lane 12 SHIFT → next cycle all outputs 0 and state IDLE. A fresh start then completes a normal 755-cycle pass.
- Check read/write mutual exclusion and the per-lane write order: assertion over the full pass; index at each write equals 0,1,…,24.

Source files
------------

// File: rtl/inv_rotate_if.sv
// Lane-memory port bundle between inv_rotate and the shared lane memory file.
interface inv_rotate_if #(
  parameter int LANE_W = 64
);
  logic              start;
  logic [LANE_W-1:0] lane_in;
  logic              read;
  logic              write;
  logic [4:0]        index;
  logic [LANE_W-1:0] lane_out;
  logic              busy;
  logic              done;

  modport master (
    input  start, lane_in,
    output read, write, index, lane_out, busy, done
  );

  modport slave (
    output start, lane_in,
    input  read, write, index, lane_out, busy, done
  );
endinterface

// File: rtl/inv_rotate.sv
// Keccak inverse rho: rotates each of the 25 lanes right by its rho offset, in place.
// Define INV_ROTATE_BARREL_EN for a single-cycle barrel rotate instead of bit-serial SHIFT.
module inv_rotate #(
  parameter int LANE_W  = 64,
  parameter int N_LANES = 25
) (
  input  logic         clk,
  input  logic         rst,
  inv_rotate_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] lane_out_q;
  logic [5:0]        cnt_q;
  logic [4:0]        index_q;
  logic              read_q;
  logic              write_q;
  logic              busy_q;
  logic              done_q;

  function automatic int rho(input logic [4:0] i);
    case (i)
      5'd0:    return 0;
      5'd1:    return 1;
      5'd2:    return 62;
      5'd3:    return 28;
      5'd4:    return 27;
      5'd5:    return 36;
      5'd6:    return 44;
      5'd7:    return 6;
      5'd8:    return 55;
      5'd9:    return 20;
      5'd10:   return 3;
      5'd11:   return 10;
      5'd12:   return 43;
      5'd13:   return 25;
      5'd14:   return 39;
      5'd15:   return 41;
      5'd16:   return 45;
      5'd17:   return 15;
      5'd18:   return 21;
      5'd19:   return 8;
      5'd20:   return 18;
      5'd21:   return 2;
      5'd22:   return 61;
      5'd23:   return 56;
      5'd24:   return 14;
      default: return 0;
    endcase
  endfunction

  logic [5:0]        off_w;
  logic [5:0]        off_m1_w;
  logic [LANE_W-1:0] ror1_w;

  assign off_w    = 6'(rho(index_q) % LANE_W);
  assign off_m1_w = off_w - 6'd1;
  assign ror1_w   = {lane_q[0], lane_q[LANE_W-1:1]};

`ifdef INV_ROTATE_BARREL_EN
  logic [LANE_W-1:0] rot_w;

  always_comb begin
    rot_w = '0;
    for (int i = 0; i < LANE_W; i++) begin
      rot_w[i] = bus.lane_in[(i + int'(off_w)) % LANE_W];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lane_q     <= '0;
      lane_out_q <= '0;
      cnt_q      <= '0;
      index_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_READ;
            index_q <= '0;
            busy_q  <= 1'b1;
            read_q  <= 1'b1;
          end
        end
        S_READ: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          cnt_q <= '0;
`ifdef INV_ROTATE_BARREL_EN
          lane_q     <= rot_w;
          lane_out_q <= rot_w;
          write_q    <= 1'b1;
          state_q    <= S_WRITE;
`else
          lane_q <= bus.lane_in;
          if (off_w == 6'd0) begin
            lane_out_q <= bus.lane_in;
            write_q    <= 1'b1;
            state_q    <= S_WRITE;
          end else begin
            state_q <= S_SHIFT;
          end
`endif
        end
        S_SHIFT: begin
          lane_q <= ror1_w;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == off_m1_w) begin
            lane_out_q <= ror1_w;
            write_q    <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (index_q == 5'(N_LANES - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            index_q <= index_q + 5'd1;
            read_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.read     = read_q;
  assign bus.write    = write_q;
  assign bus.index    = index_q;
  assign bus.lane_out = lane_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_inv_rotate.sv
// Directed bench for inv_rotate with a behavioural lane memory.
module tb_inv_rotate;

`ifdef INV_ROTATE_BARREL_EN
  localparam int EXP_DONE = 76;
`else
  localparam int EXP_DONE = 756;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inv_rotate_if #(.LANE_W(64)) bus ();

  inv_rotate #(.LANE_W(64), .N_LANES(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int off [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43,
                   25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic [63:0] mem [25];
  logic [63:0] rdata = '0;
  assign bus.lane_in = rdata;

  always @(posedge clk) begin
    if (bus.read) rdata <= mem[bus.index];
    if (bus.write) mem[bus.index] = bus.lane_out;
  end

  int vec = 0;
  int bad = 0;
  int wr_exp = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // write order and read/write exclusion, sampled mid-cycle
  always @(negedge clk) begin
    if (rst && bus.write) begin
      chk("wr_index", 64'(bus.index), 64'(wr_exp));
      wr_exp++;
      wr_cnt++;
    end
    if (bus.read && bus.write) chk("rd_wr_excl", 64'd1, 64'd0);
  end

  function automatic logic [63:0] rotl(input logic [63:0] v, input int r);
    return (r == 0) ? v : ((v << r) | (v >> (64 - r)));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int r);
    return (r == 0) ? v : ((v >> r) | (v << (64 - r)));
  endfunction

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_read"},  64'(bus.read),  64'd0);
    chk({tag, "_write"}, 64'(bus.write), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy),  64'd0);
    chk({tag, "_done"},  64'(bus.done),  64'd0);
    chk({tag, "_index"}, 64'(bus.index), 64'd0);
    chk({tag, "_lout"},  bus.lane_out,   64'd0);
  endtask

  // start pulse at cycle 0; optional re-assertion of start over [lo,hi]
  task automatic run_pass(input int lo, input int hi, output int dcyc);
    int cyc;
    dcyc = -1;
    wr_exp = 0;
    wr_cnt = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    bus.start = 1'b0;
    chk("first_read", 64'(bus.read), 64'd1);
    chk("busy_set", 64'(bus.busy), 64'd1);
    while (cyc <= 2000 && dcyc < 0) begin
      bus.start = (cyc >= lo && cyc <= hi);
      if (bus.done) dcyc = cyc;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    chk("busy_at_done", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(bus.done), 64'd0);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("no_restart", 64'(bus.read), 64'd0);
  endtask

  typedef struct {
    int          lane;
    logic [63:0] din;
    logic [63:0] dout;
  } vec_t;

  vec_t        tbl [12];
  logic [63:0] orig [25];
  int          dc;
  int          n;

  initial begin
    tbl[0]  = '{0,  64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
    tbl[1]  = '{1,  64'h1,                   64'h8000_0000_0000_0000};
    tbl[2]  = '{2,  64'h1,                   64'h4};
    tbl[3]  = '{3,  64'h1,                   64'h0000_0010_0000_0000};
    tbl[4]  = '{24, 64'h1,                   64'h0004_0000_0000_0000};
    tbl[5]  = '{7,  64'hFF,                  64'hFC00_0000_0000_0003};
    tbl[6]  = '{10, 64'h8000_0000_0000_0000, 64'h1000_0000_0000_0000};
    tbl[7]  = '{21, 64'h5,                   64'h4000_0000_0000_0001};
    tbl[8]  = '{4,  64'h0000_0000_0800_0000, 64'h1};
    tbl[9]  = '{23, 64'hAB,                  64'hAB00};
    tbl[10] = '{5,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[11] = '{9,  64'h0000_0000_0010_0000, 64'h1};

    bus.start = 1'b0;
    for (int i = 0; i < 25; i++) mem[i] = '0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outs("rst");
    rst = 1'b1;

    // directed lane vectors, untouched lanes stay zero
    for (int i = 0; i < 12; i++) mem[tbl[i].lane] = tbl[i].din;
    run_pass(0, 0, dc);
    chk("cycles_p1", 64'(dc), 64'(EXP_DONE));
    chk("writes_p1", 64'(wr_cnt), 64'd25);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("lane%0d", tbl[i].lane), mem[tbl[i].lane], tbl[i].dout);
    end
    chk("lane6_zero", mem[6], 64'd0);

    // encoder rotate then decode, with start held over 100..200
    for (int i = 0; i < 25; i++) begin
      orig[i] = {$urandom, $urandom};
      mem[i] = rotl(orig[i], off[i]);
    end
    run_pass(100, 200, dc);
    chk("cycles_p2", 64'(dc), 64'(EXP_DONE));
    chk("writes_p2", 64'(wr_cnt), 64'd25);
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("rt_lane%0d", i), mem[i], orig[i]);
    end

    // reset mid-pass during lane 12
    for (int i = 0; i < 25; i++) begin
      orig[i] = {$urandom, $urandom};
      mem[i] = orig[i];
    end
    wr_exp = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (bus.index != 5'd12 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_lane12", 64'(bus.index), 64'd12);
    repeat (5) @(posedge clk);
    #1;
`ifndef INV_ROTATE_BARREL_EN
    chk("in_shift", 64'(bus.read | bus.write), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_zero_outs("midrst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_no_read", 64'(bus.read), 64'd0);
    chk("lane11_done", mem[11], rotr(orig[11], off[11]));
    chk("lane12_kept", mem[12], orig[12]);
    run_pass(0, 0, dc);
    chk("cycles_p3", 64'(dc), 64'(EXP_DONE));
    chk("writes_p3", 64'(wr_cnt), 64'd25);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
